// File: rtl/simple_connect.sv
// Zero-latency pass-through bus with a clocked monitor: registered mirror,
// change-detect pulse, saturating change counter and combinational parity.
module simple_connect #(
    parameter int DW    = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [DW-1:0]    d_in,
    output logic [DW-1:0]    d_out,
    output logic [DW-1:0]    d_out_r,
    output logic             chg,
    output logic [CNT_W-1:0] chg_cnt,
    output logic             parity
);

    logic [DW-1:0]    prev_q, prev_d;
    logic [DW-1:0]    mirror_q, mirror_d;
    logic             chg_q, chg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             diff;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Primary path never touches clk or resetn.
    assign d_out  = d_in;
    assign parity = ^d_in;

    always_comb begin
        diff     = (d_in != prev_q);
        prev_d   = d_in;
        mirror_d = d_in;
        chg_d    = diff;
        cnt_d    = diff ? sat_inc(cnt_q) : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            prev_q   <= '0;
            mirror_q <= '0;
            chg_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            prev_q   <= prev_d;
            mirror_q <= mirror_d;
            chg_q    <= chg_d;
            cnt_q    <= cnt_d;
        end
    end

    assign d_out_r = mirror_q;
    assign chg     = chg_q;
    assign chg_cnt = cnt_q;

endmodule

// File: tb/tb_simple_connect.sv
// Bench for simple_connect: directed vector table, saturation and mid-run
// reset sequences, then random traffic against a sample-history model.
module tb_simple_connect;

    logic        clk = 1'b0;
    logic        run = 1'b0;

    logic        resetn;
    logic [7:0]  d_in;
    logic [7:0]  d_out, d_out_r;
    logic        chg, parity;
    logic [15:0] chg_cnt;

    logic        resetn4;
    logic [7:0]  d_in4;
    logic [7:0]  d_out4, d_out_r4;
    logic        chg4, parity4;
    logic [3:0]  chg_cnt4;

    int checks   = 0;
    int failures = 0;

    // Model: last sample since reset (0 after reset) and unbounded change tally.
    logic [7:0]  m_prev;
    logic [7:0]  m_r;
    logic        m_chg;
    int          m_changes;

    simple_connect #(.DW(8), .CNT_W(16)) dut (
        .clk(clk), .resetn(resetn), .d_in(d_in), .d_out(d_out),
        .d_out_r(d_out_r), .chg(chg), .chg_cnt(chg_cnt), .parity(parity)
    );

    simple_connect #(.DW(8), .CNT_W(4)) dut4 (
        .clk(clk), .resetn(resetn4), .d_in(d_in4), .d_out(d_out4),
        .d_out_r(d_out_r4), .chg(chg4), .chg_cnt(chg_cnt4), .parity(parity4)
    );

    initial forever begin
        #5;
        if (run) clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic        rst;
        logic [7:0]  d;
        logic [7:0]  r;
        logic        c;
        logic [15:0] cnt;
        logic        par;
    } vec_t;

    vec_t tbl[6];

    function automatic logic ref_par(input logic [7:0] v);
        return ($countones(v) % 2) == 1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step8(input logic rst, input logic [7:0] d);
        @(negedge clk);
        resetn = rst;
        d_in   = d;
        @(posedge clk);
        if (!rst) begin
            m_prev = 8'h00; m_r = 8'h00; m_chg = 1'b0; m_changes = 0;
        end else begin
            m_chg = (d != m_prev);
            if (m_chg) m_changes++;
            m_prev = d;
            m_r    = d;
        end
        #1;
    endtask

    task automatic check8(input string tag);
        int exp_cnt;
        exp_cnt = (m_changes > 65535) ? 65535 : m_changes;
        check({tag, "_d_out_r"}, d_out_r, m_r);
        check({tag, "_chg"}, chg, m_chg);
        check({tag, "_chg_cnt"}, chg_cnt, exp_cnt);
        check({tag, "_d_out"}, d_out, d_in);
        check({tag, "_parity"}, parity, ref_par(d_in));
    endtask

    task automatic step4(input logic rst, input logic [7:0] d);
        @(negedge clk);
        resetn4 = rst;
        d_in4   = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] v;
        logic       r;
        int         exp4;

        resetn = 1'b0; d_in = 8'h00;
        resetn4 = 1'b0; d_in4 = 8'h00;
        m_prev = 8'h00; m_r = 8'h00; m_chg = 1'b0; m_changes = 0;

        tbl[0] = '{1'b0, 8'hA5, 8'h00, 1'b0, 16'd0, 1'b0};
        tbl[1] = '{1'b0, 8'hA5, 8'h00, 1'b0, 16'd0, 1'b0};
        tbl[2] = '{1'b1, 8'h00, 8'h00, 1'b0, 16'd0, 1'b0};
        tbl[3] = '{1'b1, 8'h81, 8'h81, 1'b1, 16'd1, 1'b0};
        tbl[4] = '{1'b1, 8'h81, 8'h81, 1'b0, 16'd1, 1'b0};
        tbl[5] = '{1'b1, 8'h09, 8'h09, 1'b1, 16'd2, 1'b0};

        // Pass-through with the clock stopped.
        d_in = 8'h24;
        #10;
        check("pt_d_out_24", d_out, 8'h24);
        check("pt_parity_24", parity, 1'b0);
        for (int i = 0; i < 9; i++) begin
            v = 8'($urandom);
            d_in = v;
            #10;
            check("pt_d_out", d_out, v);
            check("pt_parity", parity, ref_par(v));
        end

        run = 1'b1;

        for (int i = 0; i < 6; i++) begin
            step8(tbl[i].rst, tbl[i].d);
            check("tbl_d_out_r", d_out_r, tbl[i].r);
            check("tbl_chg", chg, tbl[i].c);
            check("tbl_chg_cnt", chg_cnt, tbl[i].cnt);
            check("tbl_d_out", d_out, tbl[i].d);
            check("tbl_parity", parity, tbl[i].par);
        end

        // Saturation on the 4-bit counter instance.
        step4(1'b0, 8'h00);
        check("sat_reset_cnt", chg_cnt4, 4'd0);
        for (int k = 1; k <= 20; k++) begin
            step4(1'b1, (k % 2 == 1) ? 8'h55 : 8'hAA);
            exp4 = (k > 15) ? 15 : k;
            check("sat_chg_cnt", chg_cnt4, exp4);
            check("sat_chg", chg4, 1'b1);
        end
        check("sat_d_out_r", d_out_r4, 8'hAA);

        // Mid-run reset with counter at 5.
        step8(1'b0, 8'h00);
        for (int k = 1; k <= 5; k++) step8(1'b1, 8'(k));
        check("mid_cnt5", chg_cnt, 16'd5);
        step8(1'b0, 8'h3C);
        check("mid_rst_cnt", chg_cnt, 16'd0);
        check("mid_rst_r", d_out_r, 8'h00);
        check("mid_rst_chg", chg, 1'b0);
        check("mid_rst_d_out", d_out, 8'h3C);
        check("mid_rst_parity", parity, 1'b0);
        step8(1'b1, 8'h3C);
        check("mid_rel_chg", chg, 1'b1);
        check("mid_rel_cnt", chg_cnt, 16'd1);
        check("mid_rel_r", d_out_r, 8'h3C);

        // Random traffic, with repeats, occasional resets and mid-cycle glitches.
        for (int i = 0; i < 300; i++) begin
            r = ($urandom_range(0, 24) != 0);
            v = ($urandom_range(0, 2) == 0) ? m_prev : 8'($urandom);
            step8(r, v);
            check8("rnd");
            d_in = 8'($urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/simple_connect.md
# simple_connect

Byte-wide pass-through block that ties an upstream data bus straight to a downstream consumer with zero latency. It carries a small clocked monitor alongside the pass-through path: a registered copy of the bus, a change-detect pulse, a saturating change counter and a parity bit. It is a leaf block that sits inline on any point-to-point data bus where a mirrored, observable copy is needed without disturbing the primary path.

## Interface
- DW, 8: data bus width (bits); all data ports are DW wide.
- CNT_W, 16: width of the change counter.

- clk  in  1  single system clock; all state updates on its rising edge.
- resetn  in  1  synchronous, active-low reset, sampled on rising clk.
- d_in  in  DW  data input.
- d_out  out  DW  data output; combinational copy of d_in.
- d_out_r  out  DW  registered copy of d_in.
- chg  out  1  one-cycle pulse: sampled d_in differs from the previous sample.
- chg_cnt  out  CNT_W  saturating count of chg pulses since reset.
- parity  out  1  even parity of d_in (XOR of all d_in bits), combinational.

## Operation
- Primary path: d_out = d_in bit-for-bit, purely combinational.
- d_out has no register and no reset dependency; it follows d_in during reset too.
- parity = XOR reduction of d_in: 1 when an odd number of bits is set. Combinational, not reset-gated.
- Internal register prev (DW bits) holds the last sampled d_in.
- Each rising clk with resetn=1:
  - d_out_r <= d_in and prev <= d_in.
  - chg <= (d_in != prev).
  - If d_in != prev and chg_cnt != all-ones, then chg_cnt <= chg_cnt + 1.
- chg_cnt saturates at 2^CNT_W-1 (0xFFFF at the default width). It holds there and never wraps.
- Each rising clk with resetn=0: d_out_r, prev, chg and chg_cnt all go to 0. Reset takes priority over every update.
- After reset, prev = 0. The first sample of a nonzero d_in therefore counts as a change; a first sample of 0 does not.
- No handshake; d_in is treated as valid on every cycle.

## Timing
- d_out and parity: zero latency, combinational from d_in. There is no path from clk or resetn to these outputs.
- d_out_r: one cycle of latency. It shows the d_in value sampled at the previous rising edge.
- chg: registered, aligned with d_out_r. It is high for exactly the one cycle following a sampled change.
  - d_in changing on every sample keeps chg high continuously.
  - d_in held steady gives chg = 0 from the second cycle onward.
- chg_cnt: updates on the same edge that asserts chg, so its value includes the current chg pulse.
- d_in glitches between clock edges do not affect chg or chg_cnt. Only the values sampled at rising edges matter.
- Reset values (registered outputs): d_out_r=0, chg=0, chg_cnt=0.
- Reset asserted mid-operation: all registered outputs are 0 on the edge after resetn is sampled low. d_out and parity keep following d_in.
- Reset release: the first edge with resetn=1 compares d_in against prev=0.

## Test plan
- Pass-through: apply 10 random bytes, one per 10 ns, no clock activity -> d_out == d_in and parity == ^d_in after each settle, for example d_in=0x24 -> d_out=0x24, parity=0.
- Reset values: hold resetn=0 for 2 cycles with d_in=0xA5 -> d_out_r=0, chg=0, chg_cnt=0; meanwhile d_out=0xA5, parity=0.
- Registered path and change detect: release reset, then drive d_in 0x00, 0x81, 0x81, 0x09 on successive edges -> d_out_r follows one cycle late, chg sequence is 0,1,0,1, chg_cnt ends at 2.
- Saturation: with CNT_W=4, toggle d_in between 0x55 and 0xAA for 20 cycles -> chg_cnt stops at 15 and stays there while chg keeps pulsing.
- Mid-run reset: counter at 5, pulse resetn low for 1 cycle with d_in=0x3C -> next edge gives chg_cnt=0, d_out_r=0. The first edge after release gives chg=1 and chg_cnt=1, since 0x3C != 0.
